// File: rtl/pixel_thread_dispatcher_if.sv
// pixel_thread_dispatcher_if
//   Bundles the frame control, region, core back-pressure and pixel output
//   signals of the pixel thread dispatcher.
//   slave  : the dispatcher's view (controls/region/core_full in, pixels out)
//   master : the frame controller / core array view (the opposite directions)
// Signals:
//   start, abort      frame control
//   x0, y0, x1, y1    inclusive pixel region
//   core_full         per-core almost-full
//   out_valid         one-hot FIFO write strobe
//   out_x, out_y      pixel coordinate
//   busy, frame_done  frame status
//   issued_count      pixels issued in the current/last frame
interface pixel_thread_dispatcher_if #(
  parameter int NCORES  = 4,
  parameter int COORD_W = 10
);
  logic                   start;
  logic                   abort;
  logic [COORD_W-1:0]     x0;
  logic [COORD_W-1:0]     y0;
  logic [COORD_W-1:0]     x1;
  logic [COORD_W-1:0]     y1;
  logic [NCORES-1:0]      core_full;
  logic [NCORES-1:0]      out_valid;
  logic [COORD_W-1:0]     out_x;
  logic [COORD_W-1:0]     out_y;
  logic                   busy;
  logic                   frame_done;
  logic [2*COORD_W-1:0]   issued_count;

  modport master (
    output start, abort, x0, y0, x1, y1, core_full,
    input  out_valid, out_x, out_y, busy, frame_done, issued_count
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, core_full,
    output out_valid, out_x, out_y, busy, frame_done, issued_count
  );
endinterface

// File: rtl/pixel_thread_dispatcher.sv
// pixel_thread_dispatcher
//   Walks a rectangular pixel region in raster order and hands one pixel per
//   cycle to a set of ray cores, round-robin, respecting each core's
//   almost-full flag. All outputs are registered.
// Ports:
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     pixel_thread_dispatcher_if.slave (see interface file)
// Parameters:
//   NCORES  number of cores served (1..16)
//   COORD_W coordinate width in bits
// Configuration macro:
//   THREAD_DISPATCH_SKIP_FULL_EN  defined: a full core is skipped and the
//   next not-full core (searching upward from the rr pointer, wrapping) is
//   used. Undefined: strict round-robin, stall until the rr core has room.
module pixel_thread_dispatcher #(
  parameter int NCORES  = 4,
  parameter int COORD_W = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  pixel_thread_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COORD_W-1:0]   ONE_C   = 1;
  localparam logic [2*COORD_W-1:0] ONE_CNT = 1;

  state_t                 r_state;
  logic [COORD_W-1:0]     r_x0;
  logic [COORD_W-1:0]     r_x1;
  logic [COORD_W-1:0]     r_y1;
  logic [COORD_W-1:0]     r_curX;
  logic [COORD_W-1:0]     r_curY;
  logic [COORD_W-1:0]     r_outX;
  logic [COORD_W-1:0]     r_outY;
  logic [NCORES-1:0]      r_outValid;
  logic                   r_frameDone;
  logic [2*COORD_W-1:0]   r_issued;
  logic [3:0]             r_rr;

  logic [15:0]            w_full16;
  logic                   w_found;
  logic [3:0]             w_sel;
  logic [3:0]             w_rrNext;
  logic [NCORES-1:0]      w_onehot;
  logic                   w_lastX;
  logic                   w_lastPix;
`ifdef THREAD_DISPATCH_SKIP_FULL_EN
  logic [4:0]             w_cand;
`endif

  // Pad the full flags to 16 bits; non-existent cores read as full so a
  // 4-bit pointer can index the vector directly.
  assign w_full16 = ~(16'(~bus.core_full));

  // Core selection. In skip mode the loop runs from the farthest offset
  // down to zero so the nearest not-full core (from rr upward) wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr;
`ifdef THREAD_DISPATCH_SKIP_FULL_EN
    w_cand  = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr} + 5'(k);
      if (w_cand >= 5'(NCORES)) w_cand = w_cand - 5'(NCORES);
      if (!w_full16[w_cand[3:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[3:0];
      end
    end
`else
    w_found = !w_full16[r_rr];
`endif
  end

  // One-hot strobe for the selected core and the rr pointer after it.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NCORES; i++) w_onehot[i] = (w_sel == 4'(i));
    w_rrNext = (w_sel == 4'(NCORES - 1)) ? 4'd0 : w_sel + 4'd1;
  end

  // End-of-row / end-of-frame are detected by comparison before any
  // increment, so an all-ones x1/y1 never wraps.
  assign w_lastX   = (r_curX == r_x1);
  assign w_lastPix = w_lastX && (r_curY == r_y1);

  // Frame FSM with registered outputs. Strobes and frame_done default low
  // every cycle so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_curX      <= '0;
      r_curY      <= '0;
      r_outX      <= '0;
      r_outY      <= '0;
      r_outValid  <= '0;
      r_frameDone <= 1'b0;
      r_issued    <= '0;
      r_rr        <= '0;
    end else begin
      r_outValid  <= '0;
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_x0     <= bus.x0;
            r_x1     <= bus.x1;
            r_y1     <= bus.y1;
            r_curX   <= bus.x0;
            r_curY   <= bus.y0;
            r_issued <= '0;
            r_rr     <= '0;
            r_state  <= ((bus.x0 > bus.x1) || (bus.y0 > bus.y1)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (w_found) begin
            r_outValid <= w_onehot;
            r_outX     <= r_curX;
            r_outY     <= r_curY;
            r_issued   <= r_issued + ONE_CNT;
            r_rr       <= w_rrNext;
            if (w_lastPix) begin
              r_state <= DONE;
            end else if (w_lastX) begin
              r_curX <= r_x0;
              r_curY <= r_curY + ONE_C;
            end else begin
              r_curX <= r_curX + ONE_C;
            end
          end
        end
        DONE: begin
          r_frameDone <= !bus.abort;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid    = r_outValid;
  assign bus.out_x        = r_outX;
  assign bus.out_y        = r_outY;
  assign bus.busy         = (r_state == RUN);
  assign bus.frame_done   = r_frameDone;
  assign bus.issued_count = r_issued;

endmodule

// File: tb/tb_pixel_thread_dispatcher.sv
// tb_pixel_thread_dispatcher
//   Scoreboard bench: directed frames push their expected pixel strobes into
//   a queue; a negedge monitor pops and compares every strobe the DUT shows.
//   Frame-level timing (first strobe, frame_done cycle, counts) is checked
//   by the stimulus process.
module tb_pixel_thread_dispatcher;
  localparam int NC = 4;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  pixel_thread_dispatcher_if #(.NCORES(NC), .COORD_W(CW)) bus();

  pixel_thread_dispatcher #(.NCORES(NC), .COORD_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int core;
    int x;
    int y;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad = 0;
  int fi, st, di, dn;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int core, input int x, input int y);
    exp_t e;
    e.core = core;
    e.x = x;
    e.y = y;
    expQ.push_back(e);
  endtask

  // Present a one-cycle start with the given region; returns 1ns after the
  // accepting edge.
  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x0 = CW'(x0);
    bus.y0 = CW'(y0);
    bus.x1 = CW'(x1);
    bus.y1 = CW'(y1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Watch n negedges; report first strobe index, strobe count, frame_done
  // index and frame_done count (indices start at 1, 0 = never).
  task automatic runWindow(input int n, output int firstIdx, output int strobes,
                           output int doneIdx, output int dones);
    firstIdx = 0;
    strobes = 0;
    doneIdx = 0;
    dones = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.out_valid != '0) begin
        strobes++;
        if (firstIdx == 0) firstIdx = i;
      end
      if (bus.frame_done) begin
        dones++;
        if (doneIdx == 0) doneIdx = i;
      end
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.out_valid != '0) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected strobe: got out_valid=%0d x=%0d y=%0d, expected none",
                 bus.out_valid, bus.out_x, bus.out_y);
      end else begin
        e = expQ.pop_front();
        checkOutput("strobe core", int'(bus.out_valid), 1 << e.core);
        checkOutput("strobe x", int'(bus.out_x), e.x);
        checkOutput("strobe y", int'(bus.out_y), e.y);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.x1 = '0;
    bus.y1 = '0;
    bus.core_full = '0;

    // Reset state
    #12;
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset frame_done", int'(bus.frame_done), 0);
    checkOutput("reset issued", int'(bus.issued_count), 0);
    @(negedge clk);
    resetn = 1'b1;

    // 4x2 region, no back-pressure
    for (int i = 0; i < 8; i++) pushExp(i % 4, i % 4, i / 4);
    applyStimulus(0, 0, 3, 1);
    runWindow(12, fi, st, di, dn);
    checkOutput("basic first strobe idx", fi, 2);
    checkOutput("basic strobes", st, 8);
    checkOutput("basic done idx", di, 10);
    checkOutput("basic done count", dn, 1);
    checkOutput("basic issued", int'(bus.issued_count), 8);
    checkOutput("basic busy after", int'(bus.busy), 0);

    // abort and start together in IDLE: start ignored
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.x0 = 0; bus.y0 = 0; bus.x1 = 1; bus.y1 = 1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("abort+start busy", int'(bus.busy), 0);
    runWindow(4, fi, st, di, dn);
    checkOutput("abort+start strobes", st, 0);
    checkOutput("abort+start done", dn, 0);
    checkOutput("abort+start issued kept", int'(bus.issued_count), 8);

    // core 1 full
    bus.core_full = 4'b0010;
`ifdef THREAD_DISPATCH_SKIP_FULL_EN
    pushExp(0, 0, 0); pushExp(2, 1, 0); pushExp(3, 2, 0);
`else
    pushExp(0, 0, 0); pushExp(1, 1, 0); pushExp(2, 2, 0);
`endif
    applyStimulus(0, 0, 2, 0);
    runWindow(6, fi, st, di, dn);
`ifdef THREAD_DISPATCH_SKIP_FULL_EN
    checkOutput("skip strobes", st, 3);
    checkOutput("skip done idx", di, 5);
`else
    checkOutput("strict stall strobes", st, 1);
    checkOutput("strict stall done", dn, 0);
`endif
    bus.core_full = 4'b0000;
    runWindow(6, fi, st, di, dn);
`ifdef THREAD_DISPATCH_SKIP_FULL_EN
    checkOutput("skip tail strobes", st, 0);
    checkOutput("skip tail done", dn, 0);
`else
    checkOutput("strict resume strobes", st, 2);
    checkOutput("strict resume done", dn, 1);
`endif
    checkOutput("full1 issued", int'(bus.issued_count), 3);

    // Empty regions
    applyStimulus(5, 0, 4, 0);
    runWindow(4, fi, st, di, dn);
    checkOutput("empty x strobes", st, 0);
    checkOutput("empty x done idx", di, 2);
    checkOutput("empty x done count", dn, 1);
    checkOutput("empty x issued", int'(bus.issued_count), 0);
    applyStimulus(0, 3, 0, 2);
    runWindow(4, fi, st, di, dn);
    checkOutput("empty y strobes", st, 0);
    checkOutput("empty y done idx", di, 2);

    // All-ones corner: exactly one pixel, no wrap
    pushExp(0, 1023, 1023);
    applyStimulus(1023, 1023, 1023, 1023);
    runWindow(5, fi, st, di, dn);
    checkOutput("corner first idx", fi, 2);
    checkOutput("corner strobes", st, 1);
    checkOutput("corner done idx", di, 3);
    checkOutput("corner issued", int'(bus.issued_count), 1);
    pushExp(0, 1022, 7); pushExp(1, 1023, 7);
    applyStimulus(1022, 7, 1023, 7);
    runWindow(5, fi, st, di, dn);
    checkOutput("edge row strobes", st, 2);
    checkOutput("edge row done idx", di, 4);

    // abort after three issues
    pushExp(0, 0, 0); pushExp(1, 1, 0); pushExp(2, 2, 0);
    applyStimulus(0, 0, 3, 3);
    repeat (3) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    checkOutput("abort busy", int'(bus.busy), 0);
    runWindow(4, fi, st, di, dn);
    checkOutput("abort strobes after", st, 0);
    checkOutput("abort no done", dn, 0);
    checkOutput("abort issued", int'(bus.issued_count), 3);

    // all cores full, second start and region change mid-frame
    bus.core_full = 4'b1111;
    for (int i = 0; i < 4; i++) pushExp(i, i, 0);
    applyStimulus(0, 0, 3, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x0 = 8; bus.y0 = 8; bus.x1 = 9; bus.y1 = 9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    runWindow(8, fi, st, di, dn);
    checkOutput("stall strobes", st, 0);
    checkOutput("stall busy", int'(bus.busy), 1);
    bus.core_full = 4'b0000;
    runWindow(8, fi, st, di, dn);
    checkOutput("resume first idx", fi, 1);
    checkOutput("resume strobes", st, 4);
    checkOutput("resume done idx", di, 5);
    checkOutput("resume issued", int'(bus.issued_count), 4);

    // reset mid-frame, then start on the first edge after release
    pushExp(0, 2, 3);
    applyStimulus(2, 3, 5, 5);
    runWindow(2, fi, st, di, dn);
    checkOutput("pre-reset strobes", st, 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async reset out_valid", int'(bus.out_valid), 0);
    checkOutput("async reset out_x", int'(bus.out_x), 0);
    checkOutput("async reset out_y", int'(bus.out_y), 0);
    checkOutput("async reset busy", int'(bus.busy), 0);
    checkOutput("async reset issued", int'(bus.issued_count), 0);
    @(negedge clk);
    resetn = 1'b1;
    bus.start = 1'b1;
    bus.x0 = 4; bus.y0 = 2; bus.x1 = 4; bus.y1 = 2;
    pushExp(0, 4, 2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    runWindow(4, fi, st, di, dn);
    checkOutput("post-reset first idx", fi, 2);
    checkOutput("post-reset strobes", st, 1);
    checkOutput("post-reset done idx", di, 3);

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
